wrr_egress_scheduler: RTL
=========================

WRR_EGRESS_SCHEDULER -- requirements
Module: wrr_egress_scheduler

Interface
REQ-001 Parameter DATA_W, 12, width of each lane data word.
REQ-002 Parameter WGT_W, 3, width of each per-lane weight.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 init  input  1  configuration request; weights are sampled while the FSM is in INIT.
REQ-006 weight0..weight3  input  WGT_W each  per-lane quantum, in grants per turn.
REQ-007 src_empty  input  4  almost_empty flags of the four source FIFOs; bit i is lane i.
REQ-008 dst_almost_full  input  4  almost_full flags of the four destination FIFOs; bit i is lane i.
REQ-009 src_data0..src_data3  input  DATA_W each  source FIFO read data; valid the cycle after the pop.
REQ-010 pop  output  4  one-hot registered pop to the source FIFOs.
REQ-011 push  output  4  one-hot registered push to the destination FIFOs.
REQ-012 data_out  output  DATA_W  registered word for the destination FIFOs.
REQ-013 grant_idx  output  2  lane index of the current pop; holds the last value when idle.
REQ-014 state  output  2  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3.

Function
REQ-015 Lane i SHALL be eligible when src_empty[i]=0 and dst_almost_full[i]=0; lane i always routes to destination i.
REQ-016 FSM SHALL leave RESET for INIT on the first edge with init=1; otherwise it remains in RESET.
REQ-017 INIT:
- Weights SHALL be latched every cycle.
- Weight 0 SHALL be stored as 1.
- On init=0, the FSM SHALL go to IDLE.
REQ-018 IDLE SHALL go to ACTIVE on any eligible lane, and ACTIVE SHALL go to IDLE when no lane is eligible.
REQ-019 init=1 in IDLE or ACTIVE SHALL go to INIT, stop new pops, and let in-flight words complete.
REQ-020 Pops SHALL be issued only when the FSM's next state is ACTIVE, with at most one pop bit high per cycle.
REQ-021 Arbitration uses pointer ptr (2 bits) and credit cnt (WGT_W bits):
- If lane ptr is eligible and cnt>0, pop lane ptr and decrement cnt.
- Otherwise, search from ptr+1 mod 4 upward for the first eligible lane j. Pop j, set ptr=j, and set cnt=weight_j-1.
REQ-022 With no eligible lane, there SHALL be no pop, and ptr and cnt SHALL hold.
REQ-023 Pipeline:
- pop[i] is high in cycle t.
- src_data_i is sampled at the end of t+1.
- push[i] and data_out are high/valid in cycle t+2.
- Fixed latency is 2 cycles; throughput is 1 word per cycle.
REQ-024 push SHALL be a pulse of exactly one cycle per pop, and data_out SHALL hold its value when push=0.
REQ-025 Destination FIFOs SHALL set their almost_full threshold with at least 2 entries of margin, covering the in-flight words; the scheduler does no further accounting.
REQ-026 The pointer SHALL wrap 3 -> 0, and the credit SHALL never underflow: at cnt=0 the search of REQ-021 applies.
REQ-027 When the eligibility of lane ptr drops mid-quantum, the unused credit SHALL be forfeited, with a search on the same cycle.

Reset
REQ-028 On asserted reset:
- state=RESET.
- pop=0, push=0, data_out=0, grant_idx=0.
- ptr=3, so the first search starts at lane 0; cnt=0.
- Weights are set to 1.
- The pipeline registers are cleared.
REQ-029 Reset mid-operation SHALL discard in-flight words, with no push after the reset edge.

Verification
REQ-030 Reset, then init=1 for 2 cycles with weights 2,1,1,1, then init=0, with all lanes eligible. Required pop sequence: 0,0,1,2,3,0,0,1 from the first ACTIVE cycle, with push following 2 cycles later.
REQ-031 Only lane 2 eligible with weight2=0. Required: pop[2] every cycle (weight treated as 1), grant_idx=2, push[2] continuous after 2 cycles.
REQ-032 src_data0=0xA5A is presented the cycle after pop[0]. Required: data_out=0xA5A with push=0001 exactly 2 cycles after pop.
REQ-033 Lane 1 is granted with cnt=2 left, then dst_almost_full[1] rises. Required: on the same cycle, pop moves to lane 2 (or the next eligible lane), and lane 1 receives no further pops.
REQ-034 Reset is asserted the cycle after a pop. Required: push stays 0 and state=RESET immediately, asynchronously.
REQ-035 init is raised during ACTIVE. Required: pops stop on the next edge, the 2 in-flight pushes complete, and state=INIT.

Source files
------------

// File: rtl/wrr_egress_scheduler.sv
// Weighted round-robin scheduler moving words from four source FIFOs to four
// destination FIFOs. Lane i always feeds destination i. Pops are registered.
// Read data is captured one cycle after the pop, and the matching push comes
// out two cycles after the pop.
module wrr_egress_scheduler #(
    parameter int DATA_W = 12,
    parameter int WGT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [WGT_W-1:0]  weight0,
    input  logic [WGT_W-1:0]  weight1,
    input  logic [WGT_W-1:0]  weight2,
    input  logic [WGT_W-1:0]  weight3,
    input  logic [3:0]        src_empty,
    input  logic [3:0]        dst_almost_full,
    input  logic [DATA_W-1:0] src_data0,
    input  logic [DATA_W-1:0] src_data1,
    input  logic [DATA_W-1:0] src_data2,
    input  logic [DATA_W-1:0] src_data3,
    output logic [3:0]        pop,
    output logic [3:0]        push,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        grant_idx,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [1:0]         ptr_reg, ptr_next;
    logic [WGT_W-1:0]   cnt_reg, cnt_next;
    logic [1:0]         grant_reg, grant_next;
    logic [3:0]         pop_reg, pop_next;
    logic               pipe_valid_reg;
    logic [1:0]         pipe_lane_reg;
    logic [3:0]         push_reg;
    logic [DATA_W-1:0]  data_reg;

    logic [WGT_W-1:0]   wgt_in [4];
    logic [WGT_W-1:0]   wgt_reg [4];
    logic [DATA_W-1:0]  src_data_arr [4];
    logic [3:0]         elig;
    logic               any_elig;
    logic               search_found;
    logic [1:0]         search_lane;

    assign wgt_in[0] = weight0;
    assign wgt_in[1] = weight1;
    assign wgt_in[2] = weight2;
    assign wgt_in[3] = weight3;

    assign src_data_arr[0] = src_data0;
    assign src_data_arr[1] = src_data1;
    assign src_data_arr[2] = src_data2;
    assign src_data_arr[3] = src_data3;

    // A lane can move a word only if it has data and its destination has room.
    assign elig     = ~src_empty & ~dst_almost_full;
    assign any_elig = |elig;

    // Per-lane quantum registers, tracking the inputs while in INIT. A zero
    // weight would starve the lane, so it is stored as 1.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wgt
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wgt_reg[gi] <= WGT_W'(1);
                end else if (state_reg == ST_INIT) begin
                    wgt_reg[gi] <= (wgt_in[gi] == '0) ? WGT_W'(1) : wgt_in[gi];
                end
            end
        end
    endgenerate

    // Find the first eligible lane after ptr. Offset 4 wraps back to ptr
    // itself, so a lone eligible lane gets re-granted with a fresh quantum.
    always_comb begin
        logic [1:0] cand;
        search_found = 1'b0;
        search_lane  = ptr_reg;
        cand         = ptr_reg;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr_reg + 2'(k);
            if (!search_found && elig[cand]) begin
                search_found = 1'b1;
                search_lane  = cand;
            end
        end
    end

    // Next state, plus the arbitration decision used only when the next
    // state is ACTIVE.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        grant_next = grant_reg;
        pop_next   = 4'b0000;

        unique case (state_reg)
            ST_RESET:  if (init) state_next = ST_INIT;
            ST_INIT:   if (!init) state_next = ST_IDLE;
            ST_IDLE: begin
                if (init)          state_next = ST_INIT;
                else if (any_elig) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (init)           state_next = ST_INIT;
                else if (!any_elig) state_next = ST_IDLE;
            end
            default:   state_next = ST_RESET;
        endcase

        if (state_next == ST_ACTIVE) begin
            if (elig[ptr_reg] && cnt_reg != '0) begin
                cnt_next   = cnt_reg - WGT_W'(1);
                grant_next = ptr_reg;
                pop_next   = 4'b0001 << ptr_reg;
            end else if (search_found) begin
                // Any credit left on ptr is dropped when the lane loses eligibility.
                ptr_next   = search_lane;
                cnt_next   = wgt_reg[search_lane] - WGT_W'(1);
                grant_next = search_lane;
                pop_next   = 4'b0001 << search_lane;
            end
        end
    end

    // FSM, arbitration state and registered pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_RESET;
            ptr_reg   <= 2'd3;
            cnt_reg   <= '0;
            grant_reg <= 2'd0;
            pop_reg   <= 4'b0000;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cnt_reg   <= cnt_next;
            grant_reg <= grant_next;
            pop_reg   <= pop_next;
        end
    end

    // Read pipeline. The popped lane is remembered for one cycle, then its
    // read data is captured together with a one-cycle push. Words already in
    // flight keep moving even after the FSM leaves ACTIVE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid_reg <= 1'b0;
            pipe_lane_reg  <= 2'd0;
            push_reg       <= 4'b0000;
            data_reg       <= '0;
        end else begin
            pipe_valid_reg <= |pop_reg;
            pipe_lane_reg  <= grant_reg;
            push_reg       <= pipe_valid_reg ? (4'b0001 << pipe_lane_reg) : 4'b0000;
            if (pipe_valid_reg) begin
                data_reg <= src_data_arr[pipe_lane_reg];
            end
        end
    end

    assign pop       = pop_reg;
    assign push      = push_reg;
    assign data_out  = data_reg;
    assign grant_idx = grant_reg;
    assign state     = state_reg;

endmodule
